// File: rtl/irq_ctl.sv
// irq_ctl: interrupt controller for the 65C02 core.
// Synchronises up to 8 peripheral lines, latches edge or level requests,
// gates them with per-source and master enables, and drives a registered irq.
// A separate NMI latch is set by a synchronised rising edge of nmi_in or by a
// software write, and is cleared by the core's nmi_ack pulse.
//
// Bus handshake: a register access is a single-cycle transfer. cs qualifies
// the cycle at the rising clk edge; WE=1 writes DI, WE=0 loads DO with the
// addressed register's pre-edge value. DO then holds until the next read.
// There is no wait state and no ready signal.
module irq_ctl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cs,
  input  logic [1:0]      addr,
  input  logic            WE,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic [NSRC-1:0] src,
  input  logic            nmi_in,
  input  logic            nmi_ack,
  output logic            irq,
  output logic            nmi
);

  // Register bits at index NSRC and above are tied off.
  localparam logic [8:0] VALID9 = (9'd1 << NSRC) - 9'd1;
  localparam logic [7:0] VALID  = VALID9[7:0];

  logic [7:0] src_w;
  logic [7:0] s1, s2, s3;
  logic       n1, n2, n3;
  logic [7:0] pend, enable, mode;
  logic       master_en;
  logic       irq_q, nmi_q;

  logic       wr_en, rd_en;
  logic [7:0] w1c, src_rise, pend_nxt, hit, rd_data, ctrl_rd;
  logic [2:0] idx;
  logic       none, nmi_nxt;

  // Widen the source bus to the 8-bit register width.
  always_comb begin
    src_w = '0;
    src_w[NSRC-1:0] = src;
  end

  // Two-flop synchronisers plus a third copy for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      n1 <= 1'b0;
      n2 <= 1'b0;
      n3 <= 1'b0;
    end else begin
      s1 <= src_w & VALID;
      s2 <= s1;
      s3 <= s2;
      n1 <= nmi_in;
      n2 <= n1;
      n3 <= n2;
    end
  end

  // Next-state for pending bits, priority encode, NMI latch and read mux.
  always_comb begin
    wr_en    = cs & WE;
    rd_en    = cs & ~WE;
    src_rise = s2 & ~s3;
    w1c      = (wr_en && addr == 2'd0) ? DI : 8'h00;
    // Edge mode: a rise beats a same-cycle W1C. Level mode: track s2.
    pend_nxt = ((mode & ((pend & ~w1c) | src_rise)) | (~mode & s2)) & VALID;
    hit      = pend & enable;
    idx      = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (hit[i]) idx = 3'(i);
    end
    none     = ~|hit;
    ctrl_rd  = {none, master_en, 3'b000, idx};
    nmi_nxt  = (nmi_q & ~nmi_ack) | (n2 & ~n3) |
               (wr_en && addr == 2'd3 && DI[1]);
    case (addr)
      2'd0:    rd_data = pend;
      2'd1:    rd_data = enable;
      2'd2:    rd_data = mode;
      default: rd_data = ctrl_rd;
    endcase
  end

  // Register file, irq/nmi output flops and read-data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend      <= '0;
      enable    <= '0;
      mode      <= VALID;
      master_en <= 1'b0;
      irq_q     <= 1'b0;
      nmi_q     <= 1'b0;
      DO        <= '0;
    end else begin
      pend <= pend_nxt;
      if (wr_en) begin
        case (addr)
          2'd1:    enable    <= DI & VALID;
          2'd2:    mode      <= DI & VALID;
          2'd3:    master_en <= DI[0];
          default: ;
        endcase
      end
      irq_q <= master_en & (|hit);
      nmi_q <= nmi_nxt;
      if (rd_en) DO <= rd_data;
    end
  end

  assign irq = irq_q;
  assign nmi = nmi_q;

endmodule

// File: tb/tb_irq_ctl.sv
// tb_irq_ctl: directed bench for irq_ctl with a behavioural reference model
// compared against DO/irq/nmi on every falling clock edge.
module tb_irq_ctl;

  logic       clk;
  logic       reset_n;
  logic       cs;
  logic [1:0] addr;
  logic       WE;
  logic [7:0] DI;
  logic [7:0] DO;
  logic [7:0] src;
  logic       nmi_in;
  logic       nmi_ack;
  logic       irq;
  logic       nmi;

  int n_total = 0;
  int n_pass  = 0;

  irq_ctl #(.NSRC(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (cs),
    .addr    (addr),
    .WE      (WE),
    .DI      (DI),
    .DO      (DO),
    .src     (src),
    .nmi_in  (nmi_in),
    .nmi_ack (nmi_ack),
    .irq     (irq),
    .nmi     (nmi)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Lines as sampled at the last three clock edges (index 0 = most recent).
  logic [7:0] h_src [0:2];
  logic       h_nmi [0:2];
  logic [7:0] m_pend, m_en, m_mode, m_do;
  logic       m_men, m_irq, m_nmi;

  // One pending bit per source: edge sources latch rises and are cleared by
  // writing 1 (a rise wins); level sources mirror the synchronised line.
  function automatic logic [7:0] next_pend(input logic [7:0] pend, mode, lvl,
                                           rise, clr);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      if (!mode[i])     r[i] = lvl[i];
      else if (rise[i]) r[i] = 1'b1;
      else if (clr[i])  r[i] = 1'b0;
      else              r[i] = pend[i];
    end
    return r;
  endfunction

  // CTRL view: search upward for the first enabled pending source.
  function automatic logic [7:0] ctrl_view(input logic [7:0] pend, en, input logic men);
    int  first;
    first = -1;
    for (int i = 0; i < 8; i++)
      if (first < 0 && pend[i] && en[i]) first = i;
    if (first < 0) return {1'b1, men, 6'd0};
    return {1'b0, men, 3'b000, 3'(first)};
  endfunction

  function automatic logic [7:0] read_reg(input logic [1:0] a, input logic [7:0] pend,
                                          en, mode, input logic men);
    case (a)
      2'd0:    return pend;
      2'd1:    return en;
      2'd2:    return mode;
      default: return ctrl_view(pend, en, men);
    endcase
  endfunction

  // Model state advance on each rising edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) begin
        h_src[i] <= 8'h00;
        h_nmi[i] <= 1'b0;
      end
      m_pend <= 8'h00;
      m_en   <= 8'h00;
      m_mode <= 8'hFF;
      m_men  <= 1'b0;
      m_irq  <= 1'b0;
      m_nmi  <= 1'b0;
      m_do   <= 8'h00;
    end else begin
      h_src[0] <= src;
      h_src[1] <= h_src[0];
      h_src[2] <= h_src[1];
      h_nmi[0] <= nmi_in;
      h_nmi[1] <= h_nmi[0];
      h_nmi[2] <= h_nmi[1];
      m_pend <= next_pend(m_pend, m_mode, h_src[1], h_src[1] & ~h_src[2],
                          (cs && WE && addr == 2'd0) ? DI : 8'h00);
      m_irq  <= m_men && ((m_pend & m_en) != 8'h00);
      m_nmi  <= (h_nmi[1] && !h_nmi[2]) || (cs && WE && addr == 2'd3 && DI[1]) ||
                (m_nmi && !nmi_ack);
      if (cs && !WE) m_do <= read_reg(addr, m_pend, m_en, m_mode, m_men);
      if (cs && WE) begin
        case (addr)
          2'd1:    m_en   <= DI;
          2'd2:    m_mode <= DI;
          2'd3:    m_men  <= DI[0];
          default: ;
        endcase
      end
    end
  end

  // Scoreboard: every falling edge, outputs must match the model.
  always @(negedge clk) begin
    check("cyc_do",  DO,         m_do);
    check("cyc_irq", {7'd0, irq}, {7'd0, m_irq});
    check("cyc_nmi", {7'd0, nmi}, {7'd0, m_nmi});
  end

  // ---------------- driver tasks (start and end at a falling edge) ----------------
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; WE = 1'b1; addr = a; DI = d;
    @(negedge clk);
    cs = 1'b0; WE = 1'b0; DI = 8'h00;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; WE = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = DO;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  logic [7:0] r;

  initial begin
    reset_n = 1'b0; cs = 1'b0; WE = 1'b0; addr = 2'd0; DI = 8'h00;
    src = 8'h00; nmi_in = 1'b0; nmi_ack = 1'b0;
    idle(3);
    check("rst_do",  DO, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    check("rst_nmi", {7'd0, nmi}, 8'h00);
    reset_n = 1'b1;
    idle(2);

    // Basic edge request and irq latency.
    wr(2'd1, 8'h01);
    wr(2'd3, 8'h01);
    src = 8'h01;
    @(negedge clk);
    src = 8'h00;
    @(negedge clk); check("lat_e2", {7'd0, irq}, 8'h00);
    @(negedge clk); check("lat_e3", {7'd0, irq}, 8'h00);
    @(negedge clk); check("lat_e4", {7'd0, irq}, 8'h01);
    rd(2'd3, r);    check("ctrl_idx0", r, 8'h40);
    wr(2'd0, 8'h01); check("w1c_same", {7'd0, irq}, 8'h01);
    @(negedge clk);  check("w1c_drop", {7'd0, irq}, 8'h00);

    // Priority encoding.
    wr(2'd1, 8'h0C);
    src = 8'h0C;
    idle(4);
    rd(2'd3, r);     check("prio_2", r, 8'h42);
    wr(2'd0, 8'h04);
    rd(2'd3, r);     check("prio_3", r, 8'h43);
    wr(2'd0, 8'h08);
    rd(2'd3, r);     check("prio_none", r, 8'hC0);
    src = 8'h00;
    idle(3);

    // Level mode: W1C ignored, pending follows the line.
    wr(2'd2, 8'hFE);
    wr(2'd1, 8'h01);
    src = 8'h01;
    idle(4);         check("lvl_irq", {7'd0, irq}, 8'h01);
    wr(2'd0, 8'h01);
    @(negedge clk);  check("lvl_w1c_irq", {7'd0, irq}, 8'h01);
    rd(2'd0, r);     check("lvl_pend", r, 8'h01);
    src = 8'h00;
    @(negedge clk);
    @(negedge clk);  check("lvl_e2", {7'd0, irq}, 8'h01);
    @(negedge clk);  check("lvl_e3", {7'd0, irq}, 8'h01);
    @(negedge clk);  check("lvl_e4", {7'd0, irq}, 8'h00);
    wr(2'd2, 8'hFF);

    // Set/clear collision on bit 5, then master disable.
    src = 8'h20;
    @(negedge clk);
    @(negedge clk);
    wr(2'd0, 8'h20);
    rd(2'd0, r);     check("coll_pend", r, 8'h20);
    wr(2'd1, 8'h20);
    wr(2'd3, 8'h00);
    @(negedge clk);  check("men_off_irq", {7'd0, irq}, 8'h00);
    rd(2'd3, r);     check("men_off_idx", r, 8'h05);
    wr(2'd0, 8'h20);
    src = 8'h00;
    idle(3);

    // NMI latch.
    nmi_in = 1'b1;
    @(negedge clk);  check("nmi_e1", {7'd0, nmi}, 8'h00);
    @(negedge clk);  check("nmi_e2", {7'd0, nmi}, 8'h00);
    @(negedge clk);  check("nmi_e3", {7'd0, nmi}, 8'h01);
    nmi_ack = 1'b1;
    wr(2'd3, 8'h02);
    nmi_ack = 1'b0;  check("nmi_sw_ack", {7'd0, nmi}, 8'h01);
    nmi_ack = 1'b1;
    @(negedge clk);
    nmi_ack = 1'b0;  check("nmi_ack", {7'd0, nmi}, 8'h00);
    nmi_ack = 1'b1;
    @(negedge clk);
    nmi_ack = 1'b0;  check("nmi_ack_idle", {7'd0, nmi}, 8'h00);
    nmi_in = 1'b0;
    idle(3);

    // Asynchronous reset mid-cycle with irq and nmi asserted.
    wr(2'd1, 8'h01);
    wr(2'd3, 8'h03);
    src = 8'h01;
    idle(4);
    src = 8'h00;
    check("pre_rst_irq", {7'd0, irq}, 8'h01);
    check("pre_rst_nmi", {7'd0, nmi}, 8'h01);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_irq", {7'd0, irq}, 8'h00);
    check("arst_nmi", {7'd0, nmi}, 8'h00);
    check("arst_do",  DO, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd(2'd0, r);     check("rst_pend", r, 8'h00);
    rd(2'd1, r);     check("rst_en",   r, 8'h00);
    rd(2'd2, r);     check("rst_mode", r, 8'hFF);
    rd(2'd3, r);     check("rst_ctrl", r, 8'h80);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/irq_ctl.md
Name: irq_ctl

Overview:
- Memory-mapped interrupt controller that sits between peripheral interrupt lines and the 65C02 core's irq input.
- Synchronises up to 8 sources and latches edge or level requests, with per-source enable and a master enable.
- Presents a single registered irq to the core, plus a latched NMI with an acknowledge handshake.
- Firmware reads a priority-encoded source index and clears pending bits over the CPU bus.

Parameters:
NSRC, 8, number of interrupt sources (1..8); register bits at index NSRC and above read 0 and ignore writes.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
cs  input  1  register select, qualified by clk
addr  input  2  register address
WE  input  1  1 = write DI to register, 0 = read
DI  input  8  write data
DO  output  8  registered read data
src  input  NSRC  raw asynchronous interrupt lines, active high
nmi_in  input  1  raw asynchronous NMI line, active high
nmi_ack  input  1  one-cycle pulse from core when the NMI vector is taken
irq  output  1  registered interrupt request to core, active high
nmi  output  1  latched NMI request to core, active high

Behaviour:
- Reset (asynchronous, reset_n low):
  - DO=0, irq=0, nmi=0.
  - PEND=0, ENABLE=0, MODE=all ones (edge), master_en=0.
  - Synchroniser flops cleared.
- Synchronisers:
  - src and nmi_in each pass through 2 flops (s1, s2).
  - An edge is detected as s2 & ~s3, where s3 is a third registered copy.
- Pending, edge mode (MODE[i]=1):
  - Detected rising edge sets PEND[i].
  - Writing 1 to PEND[i] clears it; writing 0 has no effect.
  - Set and clear in the same cycle: set wins, PEND[i] stays 1.
- Pending, level mode (MODE[i]=0):
  - PEND[i] follows s2[i] every cycle; W1C is ignored.
- Mode change:
  - Switching a bit from level to edge leaves PEND[i] at its current value; it is not cleared.
- irq:
  - irq <= master_en & |(PEND & ENABLE).
  - Latency from src rising, edge mode, enabled: s1 at edge 1, s2 at edge 2, PEND at edge 3, irq at edge 4.
  - irq drops one cycle after the last enabled pending bit clears, or after master_en goes 0.
- Priority:
  - idx = lowest-numbered i with PEND[i] & ENABLE[i]; source 0 is highest.
  - none = no such i. When none, idx=0.
  - idx does not depend on master_en.
- Register map:
  - addr 0, PEND: read pending bits; write W1C as above.
  - addr 1, ENABLE: read/write.
  - addr 2, MODE: read/write; 1 = edge, 0 = level.
  - addr 3, CTRL:
    - Read: DO = {none, master_en, 3'b000, idx[2:0]}.
    - Write: DI[0] -> master_en; DI[1]=1 sets the nmi latch (software NMI); other bits ignored.
- Read timing:
  - When cs & ~WE at edge N, DO holds the value at edge N.
  - DO is captured at the same edge that samples the request and then holds until the next read.
  - Reads have no side effects.
- Write timing:
  - cs & WE at edge N updates the register at edge N.
  - The new value affects irq at edge N+1.
- NMI:
  - A rising edge of synchronised nmi_in sets the nmi latch (latency 3 clocks to nmi high).
  - nmi_ack clears it.
  - Edge (or software set) in the same cycle as nmi_ack: latch stays 1.
  - nmi_ack while nmi=0 has no effect.
  - NMI is independent of master_en, ENABLE and PEND.
- Reset mid-operation: all pending and latched state is lost; outputs go low immediately (asynchronous).

Test Plan:
- Reset, write ENABLE=0x01 and CTRL=0x01, pulse src[0] for 1 clk -> irq=1 exactly 4 clocks after the pulse. Read addr 3 -> DO=0x40. Write PEND=0x01 -> irq=0 one clock later.
- Priority: enable 0x0C, raise src[2] and src[3] edges -> CTRL read gives idx=2. Clear bit 2 -> idx=3. Clear bit 3 -> DO=0xC0 (none=1, master_en=1).
- Level mode: MODE=0xFE, src[0] held high, enabled -> writing PEND=0x01 does not clear, irq stays 1. Drop src[0] -> irq=0 four clocks later.
- Collision: src[5] edge reaching PEND in the same cycle as a W1C of bit 5 -> PEND[5]=1 afterwards. master_en=0 with pending enabled -> irq=0, idx still valid.
- NMI: nmi_in rising -> nmi=1 after 3 clocks. nmi_ack coincident with a CTRL write DI=0x02 -> nmi stays 1. Plain nmi_ack -> nmi=0.
- Async reset asserted between clock edges with irq=1 and nmi=1 -> both 0 before the next clk edge. All registers read back their reset values.
